// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI-Lite initiator that turns requester commands into
// AXI-Lite write/read transactions and returns status and read data on a response port.
module axil_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  logic                    write_q, write_d, rsp_write_q, rsp_write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      rsp_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      rsp_write_q <= rsp_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Outputs are next-state registers, so every VALID/READY is a flop and never follows a READY combinationally.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    write_d     = write_q;
    rsp_write_d = rsp_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: if (cmd_valid) begin
        write_d   = cmd_write;
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        awvalid_d = cmd_write;
        wvalid_d  = cmd_write;
        arvalid_d = !cmd_write;
        state_d   = cmd_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | (awvalid_q & AWREADY);
        w_done_d  = w_done_q | (wvalid_q & WREADY);
        awvalid_d = !aw_done_d;
        wvalid_d  = !w_done_d;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (BVALID) begin
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_rdata_d = '0;
        rsp_resp_d  = BRESP;
        state_d     = RSP;
      end
      RD_REQ: if (ARREADY) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_RESP;
      end
      RD_RESP: if (RVALID) begin
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = write_q;
        rsp_rdata_d = RDATA;
        rsp_resp_d  = RRESP;
        state_d     = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed tests with a response scoreboard and a configurable-latency AXI-Lite slave.
module tb_axil_cmd_master;
  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  axil_cmd_master dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {logic w; logic [31:0] d; logic [1:0] r;} exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, issued = 0, rsp_cnt = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Slave model configuration
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  initial begin
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
    {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
    BRESP = '0; RRESP = '0; RDATA = '0;
    {aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    forever begin
      @(posedge ACLK); #2;
      if (ARESET) begin
        {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
        {aw_got, w_got, ar_got} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
      end else begin
        if (aw_fire) aw_got = 1'b1;
        if (w_fire) w_got = 1'b1;
        if (ar_fire) ar_got = 1'b1;
        if (b_fire) begin BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_cnt = 0; end
        if (r_fire) begin RVALID = 1'b0; ar_got = 1'b0; r_cnt = 0; end
        if (AWVALID) begin AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end else begin AWREADY = 1'b0; aw_cnt = 0; end
        if (WVALID) begin WREADY = (w_cnt >= w_dly); w_cnt++; end else begin WREADY = 1'b0; w_cnt = 0; end
        if (ARVALID) begin ARREADY = (ar_cnt >= ar_dly); ar_cnt++; end else begin ARREADY = 1'b0; ar_cnt = 0; end
        if (aw_got && w_got && !BVALID) begin
          if (b_cnt >= 0) begin BVALID = 1'b1; BRESP = bresp_cfg; end
        end
        if (ar_got && !RVALID) begin
          if (r_cnt >= r_dly) begin RVALID = 1'b1; RDATA = rdata_cfg; RRESP = rresp_cfg; end
          else r_cnt++;
        end
      end
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      b_fire  = BVALID && BREADY;
      ar_fire = ARVALID && ARREADY;
      r_fire  = RVALID && RREADY;
    end
  end

  // Scoreboard monitor: compares each completed response with the oldest expectation.
  initial forever begin
    @(negedge ACLK);
    if (!ARESET && rsp_valid && rsp_ready) begin
      chk("rsp_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_write", rsp_write, e.w);
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_resp", rsp_resp, e.r);
      end
      rsp_cnt++;
    end
  end

  task automatic push_exp(input logic w, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.w = w; e.d = d; e.r = r;
    exp_q.push_back(e);
    issued++;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
  endtask

  // Returns at #1 after the accepting edge.
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic [1:0] ep);
    logic hs;
    int k;
    push_exp(w, er, ep);
    drive_cmd(w, a, d, s);
    k = 0;
    do begin
      @(negedge ACLK); hs = cmd_ready;
      @(posedge ACLK); #1; k++;
    end while (!hs && k < 100);
    chk("cmd_accept", hs, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (rsp_cnt < issued && k < 200) begin step(); k++; end
    chk("rsp_arrived", rsp_cnt, issued);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
    chk("rst_data", {AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write}, 0);
    ARESET = 1'b0;
    step();

    // Write, zero-wait slave
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    chk("w0_valids", {AWVALID, WVALID}, 2'b11);
    chk("w0_awaddr", AWADDR, 32'h10);
    chk("w0_wdata", WDATA, 32'hDEADBEEF);
    chk("w0_wstrb", WSTRB, 4'hF);
    chk("w0_cmd_ready", cmd_ready, 0);
    step();
    chk("w0_n2", {AWVALID, WVALID, BREADY}, 3'b001);
    step();
    chk("w0_rsp_valid", rsp_valid, 1);
    step();
    chk("w0_ready_again", {cmd_ready, rsp_valid}, 2'b10);
    wait_done();

    // Write, W delayed after AW
    w_dly = 3;
    do_cmd(1'b1, 32'h24, 32'hA5A5_0001, 4'h3, 32'h0, 2'b00);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("wskew_aw_low", AWVALID, 0);
      chk("wskew_w_high", WVALID, 1);
      chk("wskew_wdata", WDATA, 32'hA5A5_0001);
      chk("wskew_bready", BREADY, 0);
      step();
    end
    chk("wskew_done", {WVALID, BREADY}, 2'b01);
    wait_done();
    w_dly = 0;

    // Write, AW delayed after W
    aw_dly = 3;
    do_cmd(1'b1, 32'h38, 32'h0BAD_F00D, 4'hC, 32'h0, 2'b00);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("awskew_w_low", WVALID, 0);
      chk("awskew_aw_high", AWVALID, 1);
      chk("awskew_awaddr", AWADDR, 32'h38);
      chk("awskew_bready", BREADY, 0);
      step();
    end
    chk("awskew_done", {AWVALID, BREADY}, 2'b01);
    wait_done();
    aw_dly = 0;

    // Read with waits
    ar_dly = 2; r_dly = 4; rdata_cfg = 32'h1234_5678;
    do_cmd(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h1234_5678, 2'b00);
    k = 0;
    while (ARVALID && k < 20) begin chk("rd_araddr", ARADDR, 32'h104); step(); k++; end
    chk("rd_ar_done", {ARVALID, RREADY}, 2'b01);
    wait_done();
    ar_dly = 0; r_dly = 0;

    // Error pass-through
    bresp_cfg = 2'b10;
    do_cmd(1'b1, 32'h200, 32'h1, 4'h1, 32'h0, 2'b10);
    wait_done();
    bresp_cfg = 2'b00; rresp_cfg = 2'b11; rdata_cfg = 32'hCAFE_0003;
    do_cmd(1'b0, 32'h204, 32'h0, 4'h0, 32'hCAFE_0003, 2'b11);
    chk("rd0_arvalid", ARVALID, 1);
    step();
    chk("rd0_rready", RREADY, 1);
    step();
    chk("rd0_rsp_valid", rsp_valid, 1);
    wait_done();
    rresp_cfg = 2'b00;

    // Response back-pressure with the next command held
    rsp_ready = 1'b0; bresp_cfg = 2'b01;
    do_cmd(1'b1, 32'h300, 32'h5555_AAAA, 4'hF, 32'h0, 2'b01);
    push_exp(1'b0, 32'h7777_0000, 2'b00);
    rdata_cfg = 32'h7777_0000;
    drive_cmd(1'b0, 32'h304, 32'h0, 4'h0);
    k = 0;
    while (!rsp_valid && k < 50) begin step(); k++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, {1'b1, 2'b01, 32'h0});
      chk("bp_cmd_ready", cmd_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_after_hs", {cmd_ready, rsp_valid}, 2'b10);
    step();
    chk("bp_next_accepted", {ARVALID, cmd_ready}, 2'b10);
    cmd_valid = 1'b0;
    wait_done();
    bresp_cfg = 2'b00;

    // Reset mid-transaction
    aw_dly = 100;
    do_cmd(1'b1, 32'h400, 32'h1111_2222, 4'hF, 32'h0, 2'b00);
    step();
    chk("mid_aw_stall", {AWVALID, AWREADY}, 2'b10);
    ARESET = 1'b1;
    step();
    chk("mid_rst", {AWVALID, WVALID, rsp_valid, cmd_ready}, 4'b0001);
    step();
    ARESET = 1'b0;
    exp_q.delete();
    issued = rsp_cnt;
    aw_dly = 0; rdata_cfg = 32'h9999_8888;
    do_cmd(1'b0, 32'h408, 32'h0, 4'h0, 32'h9999_8888, 2'b00);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI-Lite initiator for the DMA controller subsystem. It converts single-beat register commands from an internal requester, such as the DMA descriptor fetch logic or a test sequencer, into AXI-Lite write or read transactions. Each command's completion status and read data are returned on a response port. One transaction is outstanding at a time, and the block is the counterpart to the AXI-Lite register slave.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; must be 32 or 64

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes
- rsp_resp  out  2  captured BRESP or RRESP
- AWADDR, AWVALID out; AWREADY in: write address channel
- WDATA, WSTRB, WVALID out; WREADY in: write data channel
- BRESP, BVALID in; BREADY out: write response channel
- ARADDR, ARVALID out; ARREADY in: read address channel
- RDATA, RRESP, RVALID in; RREADY out: read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/wdata/wstrb/write.
  - Go to WR_REQ if write, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID both assert on entry.
  - Each channel is tracked independently with an aw_done/w_done flag.
  - Each VALID drops the cycle after its own handshake.
  - Once both are done, go to WR_RESP. AW and W may complete in either order or in the same cycle.
- WR_RESP:
  - BREADY=1.
  - On BVALID, capture BRESP; rsp_rdata=0.
  - Go to RSP.
- RD_REQ:
  - ARVALID=1.
  - On ARREADY, go to RD_RESP.
- RD_RESP:
  - RREADY=1.
  - On RVALID, capture RDATA/RRESP.
  - Go to RSP.
- RSP:
  - rsp_valid=1.
  - On rsp_ready, go to IDLE.
- AXI VALID stability: once asserted, AWVALID/WVALID/ARVALID and their address, data and strobe fields hold unchanged until the handshake completes.
- No VALID depends combinationally on a READY.
- AWADDR/ARADDR are driven with cmd_addr unmodified; no alignment masking.
- ARADDR/AWADDR/WDATA/WSTRB hold the last command's values when idle.
- rsp_resp passes through unchanged. SLVERR/DECERR are reported, not retried.
- Responses hold stable while rsp_valid=1 and rsp_ready=0.
- cmd_ready is registered from state and is 0 in every state other than IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - cmd_ready=1 (the FSM resets to IDLE).
  - All AXI VALID/READY outputs are 0.
  - rsp_valid=0.
  - All data, address, strobe and response outputs are 0.
- ARESET asserted mid-transaction:
  - On the next edge the FSM returns to IDLE and every VALID/READY drops.
  - Any pending response is discarded.
  - The system resets the slave at the same time.
- Zero-wait-state slave, command accepted at edge N:
  - Write: AWVALID/WVALID high in cycle N+1; BREADY high in N+2; rsp_valid high in N+3 if BVALID was high in N+2.
  - Read: ARVALID high in N+1; RREADY high in N+2; rsp_valid high in N+3.
- If rsp_ready is high in the first rsp_valid cycle, cmd_ready is high again the cycle after.
- Throughput is 1 command per 4 cycles at best.
- Back-pressure on any channel stretches only its own state. There is no timeout; the block waits indefinitely.

## Test plan
- Write, zero-wait slave:
  - Stimulus: cmd write addr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF.
  - Response: AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF.
  - AW and W handshake in cycle N+1.
  - rsp_valid in N+3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Write, skewed channels:
  - Stimulus: slave holds WREADY low 3 cycles after AWREADY.
  - Response: AWVALID drops after its handshake; WVALID stays high with WDATA stable.
  - BREADY is asserted only after W completes.
  - Repeat with W first, then AW.
- Read with waits:
  - Stimulus: ARREADY delayed 2 cycles; RVALID delayed 4 cycles with RDATA=0x1234_5678, RRESP=0.
  - Response: ARADDR is stable while ARVALID is high.
  - rsp_rdata=0x12345678, rsp_write=0.
- Error pass-through:
  - Stimulus: BRESP=2'b10 on a write, then RRESP=2'b11 on a read.
  - Response: rsp_resp=2 and rsp_resp=3 respectively.
  - The next command is accepted normally.
- Response back-pressure:
  - Stimulus: rsp_ready low 5 cycles while cmd_valid is held high.
  - Response: rsp fields are stable; cmd_ready=0 throughout.
  - The next command is accepted the cycle after the rsp handshake.
- Reset mid-transaction:
  - Stimulus: assert ARESET while AWVALID=1 and AWREADY=0.
  - Response: the next edge gives AWVALID=0, WVALID=0, rsp_valid=0, cmd_ready=1.
  - A following read completes correctly.
